serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes diff = a - b, one bit per

---
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_subtractor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b, LSB first, one full-subtractor cell).
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_sr_r, b_sr_r, d_sr_r, diff_r;
  logic [CW-1:0]    cnt_r;
  logic             borrow_r, busy_r, done_r, bout_r;
  logic             load_s, step_s, fin_s;
  logic [1:0]       fs_s;

  // Returns {borrow_out, difference} of one full-subtractor cell.
  function automatic logic [1:0] fsub(input logic x, input logic y, input logic br);
    fsub = {(~x & y) | (~(x ^ y) & br), x ^ y ^ br};
  endfunction

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    fin_s   = 1'b0;
    fs_s    = fsub(a_sr_r[0], b_sr_r[0], borrow_r);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_SHIFT;
          load_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        // One extra edge after the last bit publishes the result in DONE.
        if (cnt_r == CNT_END) begin
          state_s = S_DONE;
          fin_s   = 1'b1;
        end else begin
          state_s = S_SHIFT;
          step_s  = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_s = S_SHIFT;
          load_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register plus registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == S_SHIFT);
      done_r  <= (state_s == S_DONE);
    end
  end

  // Operand shift registers, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      d_sr_r   <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
    end else if (load_s) begin
      a_sr_r   <= a;
      b_sr_r   <= b;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
    end else if (step_s) begin
      a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
      b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
      d_sr_r   <= {fs_s[0], d_sr_r[WIDTH-1:1]};
      borrow_r <= fs_s[1];
      cnt_r    <= cnt_r + CW'(1);
    end
  end

  // Result registers, updated only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= '0;
      bout_r <= 1'b0;
    end else if (fin_s) begin
      diff_r <= d_sr_r;
      bout_r <= borrow_r;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_r, b_msb_r, ovf_r;

  // Operand sign latches and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (load_s) begin
      a_msb_r <= a[WIDTH-1];
      b_msb_r <= b[WIDTH-1];
    end else if (fin_s) begin
      ovf_r   <= (a_msb_r != b_msb_r) && (d_sr_r[WIDTH-1] != a_msb_r);
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int unsigned  n_pass = 0;
  int unsigned  n_total = 0;
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;
  logic         held_ovf = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks that outputs still show the previously published result.
  task automatic check_held(input string tag);
    check({tag, "_diff"}, 32'(diff), 32'(held_diff));
    check({tag, "_bout"}, 32'(bout), 32'(held_bout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(held_ovf));
`endif
  endtask

  // Issues an op at the current negedge; returns at the negedge of the DONE cycle.
  // inject_busy drives a conflicting start mid-operation, which must be ignored.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input bit inject_busy);
    int          sd;
    logic [W-1:0] exp_d;
    logic        exp_b, exp_o;
    exp_d = op_a - op_b;
    exp_b = (int'(op_a) < int'(op_b));
    sd    = int'($signed(op_a)) - int'($signed(op_b));
    exp_o = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    a = op_a;
    b = op_b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i <= W; i++) begin
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      if (i == 0 || i == W) check_held("hold_shift");
      if (inject_busy && i == 2) begin
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("diff", 32'(diff), 32'(exp_d));
    check("bout", 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(ovf), 32'(exp_o));
`endif
    held_diff = exp_d;
    held_bout = exp_b;
    held_ovf  = exp_o;
  endtask

  // One idle cycle after DONE: pulse must have dropped and result must persist.
  task automatic idle_check();
    @(negedge clk);
    check("done_drop", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check_held("hold_idle");
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h05, 8'h03, 1'b0);
    idle_check();
    @(negedge clk);
    run_op(8'h03, 8'h05, 1'b0);
    idle_check();
    run_op(8'h00, 8'h00, 1'b0);
    idle_check();
    run_op(8'h80, 8'h01, 1'b0);
    idle_check();
    run_op(8'h7F, 8'hFF, 1'b0);
    idle_check();

    // Mid-op start ignored, then start held in DONE accepted back-to-back
    run_op(8'h40, 8'h11, 1'b1);
    run_op(8'hFF, 8'h00, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    idle_check();

    // Asynchronous reset mid-operation
    a = 8'h5A;
    b = 8'h21;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("arst_ovf", 32'(ovf), 32'd0);
`endif
    held_diff = '0;
    held_bout = 1'b0;
    held_ovf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
      check("no_busy_after_rst", 32'(busy), 32'd0);
    end
    check_held("hold_after_rst");

    // Random operands, mixing back-to-back and idle gaps
    for (int n = 0; n < 250; n++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
